// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and serial-unit FSM encoding.
// Used by both the bit-serial adder and subtractor.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/m_serial_adder_if.sv
// Start/busy/done handshake and operand/result bundle of the serial adder.
// The master issues operands; the slave (the adder) returns results and flags.
interface m_serial_adder_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);

   logic             iStart;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic             iCin;
   logic [WIDTH-1:0] oSum;
   logic             oCarry;
   logic             oZero;
   logic             oOverflow;
   logic             oBusy;
   logic             oDone;

   modport master (
      output iStart, iA, iB, iCin,
      input  oSum, oCarry, oZero, oOverflow, oBusy, oDone
   );

   modport slave (
      input  iStart, iA, iB, iCin,
      output oSum, oCarry, oZero, oOverflow, oBusy, oDone
   );

endinterface

// File: rtl/m_full_adder.sv
// Single-bit full adder cell; combinational sibling of the full subtractor.
// One instance is time-shared across all bit positions of the serial adder.
module m_full_adder (
   input  logic iA,
   input  logic iB,
   input  logic iC,
   output logic oSum,
   output logic oCarry
);

   assign oSum   = iA ^ iB ^ iC;
   assign oCarry = (iA & iB) | (iC & (iA ^ iB));

endmodule

// File: rtl/m_serial_adder.sv
// Bit-serial adder: operands shift LSB-first through one full adder,
// results are registered on entry to DONE and flagged one cycle later.
module m_serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input logic            iClk,
   input logic            iRst,
   m_serial_adder_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           nextState;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] aSr;
   logic [WIDTH-1:0] bSr;
   logic [WIDTH-1:0] sumSr;
   logic             carryQ;
   logic [WIDTH-1:0] sumQ;
   logic             carryOutQ;
   logic             zeroQ;
   logic             ovfQ;
   logic             doneQ;
   logic             faSum;
   logic             faCarry;
   logic             lastBit;
   logic [WIDTH-1:0] sumNext;

   m_full_adder uFa (
      .iA     (aSr[0]),
      .iB     (bSr[0]),
      .iC     (carryQ),
      .oSum   (faSum),
      .oCarry (faCarry)
   );

   assign lastBit = (count == CW'(WIDTH - 1));
   assign sumNext = {faSum, sumSr[WIDTH-1:1]};

   always_comb begin
      nextState = state;
      unique case (state)
         ST_IDLE: if (bus.iStart) nextState = ST_RUN;
         ST_RUN:  if (lastBit) nextState = ST_DONE;
         ST_DONE: nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // carryQ on the last bit is the carry into the MSB, so overflow
   // is that value XOR the final carry-out.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         count     <= '0;
         aSr       <= '0;
         bSr       <= '0;
         sumSr     <= '0;
         carryQ    <= 1'b0;
         sumQ      <= '0;
         carryOutQ <= 1'b0;
         zeroQ     <= 1'b1;
         ovfQ      <= 1'b0;
         doneQ     <= 1'b0;
      end else begin
         doneQ <= (state == ST_DONE);
         unique case (state)
            ST_IDLE: begin
               if (bus.iStart) begin
                  aSr    <= bus.iA;
                  bSr    <= bus.iB;
                  carryQ <= bus.iCin;
                  count  <= '0;
               end
            end
            ST_RUN: begin
               aSr    <= aSr >> 1;
               bSr    <= bSr >> 1;
               sumSr  <= sumNext;
               carryQ <= faCarry;
               count  <= count + 1'b1;
               if (lastBit) begin
                  sumQ      <= sumNext;
                  carryOutQ <= faCarry;
                  zeroQ     <= (sumNext == '0);
                  ovfQ      <= carryQ ^ faCarry;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.oSum      = sumQ;
   assign bus.oCarry    = carryOutQ;
   assign bus.oZero     = zeroQ;
   assign bus.oOverflow = ovfQ;
   assign bus.oBusy     = (state == ST_RUN) || (state == ST_DONE);
   assign bus.oDone     = doneQ;

endmodule

// File: tb/tb_m_serial_adder.sv
// Scoreboard bench for m_serial_adder: directed vectors plus a model-checked
// sweep; a negedge monitor pops expected results on every oDone.
module tb_m_serial_adder;

   typedef struct packed {
      logic [7:0] sum;
      logic       carry;
      logic       zero;
      logic       ovf;
   } exp_t;

   logic iClk;
   logic iRst;
   int   checks;
   int   errors;
   exp_t q[$];
   exp_t monE;

   m_serial_adder_if #(.WIDTH(8)) bus ();

   m_serial_adder #(.WIDTH(8)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge iClk) begin
      if (!iRst && bus.oDone) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got oDone=1 expected no pending op at %0t",
                     $time);
         end else begin
            monE = q.pop_front();
            chk("done_sum", 32'(bus.oSum), 32'(monE.sum));
            chk("done_carry", 32'(bus.oCarry), 32'(monE.carry));
            chk("done_zero", 32'(bus.oZero), 32'(monE.zero));
            chk("done_ovf", 32'(bus.oOverflow), 32'(monE.ovf));
         end
      end
   end

   task automatic chkResetOuts(input string tag);
      chk({tag, "_sum"}, 32'(bus.oSum), 32'h0);
      chk({tag, "_carry"}, 32'(bus.oCarry), 32'h0);
      chk({tag, "_zero"}, 32'(bus.oZero), 32'h1);
      chk({tag, "_ovf"}, 32'(bus.oOverflow), 32'h0);
      chk({tag, "_busy"}, 32'(bus.oBusy), 32'h0);
      chk({tag, "_done"}, 32'(bus.oDone), 32'h0);
   endtask

   // Issue one op from a negedge; returns at the negedge where oDone is seen.
   task automatic doOp(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input exp_t e,
                       input int glitchAt, input bit chkLat);
      logic [7:0] held;
      int lat;
      int busyCnt;
      bit seen;
      held = bus.oSum;
      q.push_back(e);
      bus.iA = a;
      bus.iB = b;
      bus.iCin = c;
      bus.iStart = 1'b1;
      @(posedge iClk);
      #1;
      bus.iStart = 1'b0;
      bus.iA = ~a;
      bus.iB = ~b;
      bus.iCin = ~c;
      lat = 0;
      busyCnt = 0;
      seen = 0;
      while (!seen && lat < 20) begin
         @(negedge iClk);
         lat++;
         if (bus.oBusy) busyCnt++;
         if (bus.oDone) seen = 1;
         else if (lat == 5) chk("held_sum", 32'(bus.oSum), 32'(held));
         if (glitchAt > 0 && lat == glitchAt) begin
            bus.iStart = 1'b1;
            bus.iA = 8'hFF;
            bus.iB = 8'hFF;
         end else begin
            bus.iStart = 1'b0;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no oDone expected within 20 cycles");
         void'(q.pop_front());
      end
      if (chkLat) begin
         chk("latency", 32'(lat), 32'd10);
         chk("busy_cycles", 32'(busyCnt), 32'd9);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic c);
      logic [8:0] r;
      exp_t e;
      r = {1'b0, a} + {1'b0, b} + {8'h0, c};
      e.sum = r[7:0];
      e.carry = r[8];
      e.zero = (r[7:0] == 8'h0);
      e.ovf = (a[7] == b[7]) && (r[7] != a[7]);
      return e;
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      iRst = 1'b1;
      bus.iStart = 1'b0;
      bus.iA = 8'h00;
      bus.iB = 8'h00;
      bus.iCin = 1'b0;
      repeat (3) @(negedge iClk);
      chkResetOuts("reset");
      iRst = 1'b0;
      @(negedge iClk);

      doOp(8'h0F, 8'h01, 1'b0, '{8'h10, 1'b0, 1'b0, 1'b0}, 0, 1);
      doOp(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0}, 0, 0);
      doOp(8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b0, 1'b1}, 0, 0);
      doOp(8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b1}, 0, 0);
      doOp(8'h64, 8'h64, 1'b0, '{8'hC8, 1'b0, 1'b0, 1'b1}, 0, 0);

      doOp(8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0, 1'b0}, 3, 0);
      repeat (12) @(negedge iClk);
      chk("post_glitch_busy", 32'(bus.oBusy), 32'h0);

      bus.iA = 8'hAA;
      bus.iB = 8'h55;
      bus.iCin = 1'b0;
      bus.iStart = 1'b1;
      @(posedge iClk);
      #1;
      bus.iStart = 1'b0;
      repeat (4) @(negedge iClk);
      iRst = 1'b1;
      #1;
      chkResetOuts("abort");
      @(negedge iClk);
      iRst = 1'b0;
      repeat (12) @(negedge iClk);
      chk("abort_idle_busy", 32'(bus.oBusy), 32'h0);

      doOp(8'h01, 8'h01, 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0}, 0, 0);
      doOp(8'h55, 8'hAA, 1'b1, '{8'h00, 1'b1, 1'b1, 1'b0}, 0, 1);
      doOp(8'h3C, 8'h0F, 1'b0, '{8'h4B, 1'b0, 1'b0, 1'b0}, 0, 1);

      for (int i = 0; i < 300; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic rc;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         doOp(ra, rb, rc, model(ra, rb, rc), 0, 0);
      end

      repeat (4) @(negedge iClk);
      chk("queue_drain", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
